// File: rtl/maze_generator_if.sv
// Interface bundle for maze_generator.
//
// Groups the start/seed request, the random-access wall readout and the
// status flags. The generator connects through the slave modport; the
// controlling stage (render pipeline or bench) uses the master modport.
//
//   start     master->slave  start request
//   seed      master->slave  16-bit LFSR seed, sampled with start
//   rd_x      master->slave  readout cell column
//   rd_y      master->slave  readout cell row
//   rd_walls  slave->master  {right_wall, down_wall} of (rd_x, rd_y), registered
//   busy      slave->master  high while clearing or carving
//   finish    slave->master  high while the finished maze is held

interface maze_generator_if #(
    parameter int unsigned COLS = 16,
    parameter int unsigned ROWS = 12
);
    localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          start;
    logic [15:0]   seed;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [1:0]    rd_walls;
    logic          busy;
    logic          finish;

    modport master (
        output start,
        output seed,
        output rd_x,
        output rd_y,
        input  rd_walls,
        input  busy,
        input  finish
    );

    modport slave (
        input  start,
        input  seed,
        input  rd_x,
        input  rd_y,
        output rd_walls,
        output busy,
        output finish
    );
endinterface

// File: rtl/maze_generator.sv
// Perfect-maze generator (depth-first recursive backtracker).
//
// On start the COLS x ROWS grid is cleared one cell per cycle, then a
// spanning tree is carved from cell (0,0) with an explicit stack, one
// push or pop per cycle, steered by a 16-bit Galois LFSR. The finished
// wall map is then held for random-access readout.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   maze_generator_if.slave: start, seed, rd_x, rd_y in;
//         rd_walls, busy, finish out (all outputs registered)
//
// Optional build macro:
//   MAZE_GEN_EXIT_EN  when defined, the right wall of cell (COLS-1, ROWS-1)
//                     is opened on the cycle carving completes.

module maze_generator #(
    parameter int unsigned COLS = 16,
    parameter int unsigned ROWS = 12
) (
    input logic            clk,
    input logic            rst,
    maze_generator_if.slave bus
);
    localparam int unsigned N   = COLS * ROWS;
    localparam int unsigned XW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned YW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SPW = $clog2(N + 1);

    localparam logic [15:0]   SeedDefault = 16'hACE1;
    localparam logic [15:0]   LfsrTaps    = 16'hB400;
    localparam logic [IW-1:0] LastIdx     = IW'(N - 1);

`ifdef MAZE_GEN_EXIT_EN
    localparam bit ExitEn = 1'b1;
`else
    localparam bit ExitEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StCarve,
        StDone
    } state_e;

    // Directions used by the carver.
    localparam logic [1:0] DirN = 2'd0;
    localparam logic [1:0] DirE = 2'd1;
    localparam logic [1:0] DirS = 2'd2;
    localparam logic [1:0] DirW = 2'd3;

    state_e         state_q;
    logic [15:0]    lfsr_q;
    logic [IW-1:0]  clr_q;
    logic [SPW-1:0] sp_q;
    logic [XW-1:0]  stk_x_q [N];
    logic [YW-1:0]  stk_y_q [N];
    logic [N-1:0]   right_q;
    logic [N-1:0]   down_q;
    logic [N-1:0]   visited_q;
    logic           busy_q;
    logic           finish_q;
    logic [1:0]     rd_walls_q;

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        return IW'(int'(y) * int'(COLS) + int'(x));
    endfunction

    // ------------------------------------------------------------------
    // Carve step: top of stack and first qualifying neighbour
    // ------------------------------------------------------------------
    logic [IW-1:0] top_ptr;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [IW-1:0] cur_idx;
    logic [XW-1:0] nb_x;
    logic [YW-1:0] nb_y;
    logic [IW-1:0] nb_idx;
    logic [1:0]    nb_dir;
    logic          nb_found;
    logic [1:0]    cand_dir;
    logic          cand_ok;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic [15:0]   lfsr_next;

    // Only meaningful while the stack is non-empty (CARVE).
    assign top_ptr = IW'(sp_q - SPW'(1));
    assign cur_x   = stk_x_q[top_ptr];
    assign cur_y   = stk_y_q[top_ptr];
    assign cur_idx = cell_idx(cur_x, cur_y);
    assign nb_idx  = cell_idx(nb_x, nb_y);

    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);

    // Candidates are tried in rotating order starting at lfsr[1:0]; the
    // first one that is in-grid and unvisited wins.
    always_comb begin
        nb_found = 1'b0;
        nb_dir   = DirN;
        nb_x     = cur_x;
        nb_y     = cur_y;
        cand_dir = DirN;
        cand_ok  = 1'b0;
        cand_x   = cur_x;
        cand_y   = cur_y;
        for (int i = 0; i < 4; i++) begin
            cand_dir = lfsr_q[1:0] + 2'(i);
            cand_ok  = 1'b0;
            cand_x   = cur_x;
            cand_y   = cur_y;
            case (cand_dir)
                DirN: if (cur_y != '0) begin
                    cand_ok = 1'b1;
                    cand_y  = cur_y - YW'(1);
                end
                DirE: if (int'(cur_x) < int'(COLS) - 1) begin
                    cand_ok = 1'b1;
                    cand_x  = cur_x + XW'(1);
                end
                DirS: if (int'(cur_y) < int'(ROWS) - 1) begin
                    cand_ok = 1'b1;
                    cand_y  = cur_y + YW'(1);
                end
                default: if (cur_x != '0) begin
                    cand_ok = 1'b1;
                    cand_x  = cur_x - XW'(1);
                end
            endcase
            if (cand_ok && !nb_found && !visited_q[cell_idx(cand_x, cand_y)]) begin
                nb_found = 1'b1;
                nb_dir   = cand_dir;
                nb_x     = cand_x;
                nb_y     = cand_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Readout addressing
    // ------------------------------------------------------------------
    logic          rd_in_range;
    logic [IW-1:0] rd_idx;

    assign rd_in_range = (int'(bus.rd_x) < int'(COLS)) && (int'(bus.rd_y) < int'(ROWS));
    assign rd_idx      = cell_idx(bus.rd_x, bus.rd_y);

    // ------------------------------------------------------------------
    // State machine and storage
    // ------------------------------------------------------------------
    // Cell and stack storage is deliberately not reset: CLEAR initialises
    // every cell before it is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= SeedDefault;
            clr_q      <= '0;
            sp_q       <= '0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            rd_walls_q <= 2'b00;
        end else begin
            // Status flags lag the state by one edge, so busy and finish
            // never overlap.
            busy_q     <= (state_q == StClear) || (state_q == StCarve);
            finish_q   <= (state_q == StDone);
            rd_walls_q <= rd_in_range ? {right_q[rd_idx], down_q[rd_idx]} : 2'b11;

            case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        lfsr_q  <= (bus.seed == 16'h0000) ? SeedDefault : bus.seed;
                        clr_q   <= '0;
                        sp_q    <= '0;
                        state_q <= StClear;
                    end
                end

                StClear: begin
                    right_q[clr_q]   <= 1'b1;
                    down_q[clr_q]    <= 1'b1;
                    visited_q[clr_q] <= 1'b0;
                    if (clr_q == LastIdx) begin
                        // Seed the walk at (0,0); last index is never 0.
                        visited_q[0] <= 1'b1;
                        stk_x_q[0]   <= '0;
                        stk_y_q[0]   <= '0;
                        sp_q         <= SPW'(1);
                        state_q      <= StCarve;
                    end else begin
                        clr_q <= clr_q + IW'(1);
                    end
                end

                StCarve: begin
                    lfsr_q <= lfsr_next;
                    if (nb_found) begin
                        visited_q[nb_idx] <= 1'b0 | 1'b1;
                        case (nb_dir)
                            DirN:    down_q[nb_idx]   <= 1'b0;
                            DirE:    right_q[cur_idx] <= 1'b0;
                            DirS:    down_q[cur_idx]  <= 1'b0;
                            default: right_q[nb_idx]  <= 1'b0;
                        endcase
                        // At most N-1 pushes follow the initial entry.
                        stk_x_q[IW'(sp_q)] <= nb_x;
                        stk_y_q[IW'(sp_q)] <= nb_y;
                        sp_q               <= sp_q + SPW'(1);
                    end else begin
                        sp_q <= sp_q - SPW'(1);
                        if (sp_q == SPW'(1)) begin
                            state_q <= StDone;
                            if (ExitEn) begin
                                right_q[LastIdx] <= 1'b0;
                            end
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.finish   = finish_q;
    assign bus.rd_walls = rd_walls_q;

endmodule

// File: tb/tb_maze_generator.sv
// Self-checking bench for maze_generator: three instances (4x4, 16x12, 2x2)
// share clock and reset. Expected wall maps come from a behavioural
// backtracker model; readout requests push expectations into a queue that
// a separate monitor pops one cycle later.

module tb_maze_generator;

`ifdef MAZE_GEN_EXIT_EN
    localparam bit ExitEn = 1'b1;
`else
    localparam bit ExitEn = 1'b0;
`endif
    localparam int MaxN = 192;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v;
    logic [15:0] seed_v;
    logic [3:0]  rx;
    logic [3:0]  ry;

    maze_generator_if #(.COLS(4),  .ROWS(4))  bus4  ();
    maze_generator_if #(.COLS(16), .ROWS(12)) bus16 ();
    maze_generator_if #(.COLS(2),  .ROWS(2))  bus2  ();

    assign bus4.start  = start_v[0];
    assign bus16.start = start_v[1];
    assign bus2.start  = start_v[2];
    assign bus4.seed   = seed_v;
    assign bus16.seed  = seed_v;
    assign bus2.seed   = seed_v;
    assign bus4.rd_x   = rx[1:0];
    assign bus4.rd_y   = ry[1:0];
    assign bus16.rd_x  = rx;
    assign bus16.rd_y  = ry;
    assign bus2.rd_x   = rx[0:0];
    assign bus2.rd_y   = ry[0:0];

    maze_generator #(.COLS(4),  .ROWS(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    maze_generator #(.COLS(16), .ROWS(12)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    maze_generator #(.COLS(2),  .ROWS(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    function automatic logic get_busy(input int s);
        case (s)
            0:       return bus4.busy;
            1:       return bus16.busy;
            default: return bus2.busy;
        endcase
    endfunction

    function automatic logic get_finish(input int s);
        case (s)
            0:       return bus4.finish;
            1:       return bus16.finish;
            default: return bus2.finish;
        endcase
    endfunction

    function automatic logic [1:0] get_walls(input int s);
        case (s)
            0:       return bus4.rd_walls;
            1:       return bus16.rd_walls;
            default: return bus2.rd_walls;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model: recursive backtracker on plain arrays
    // ------------------------------------------------------------------
    bit m_right [MaxN];
    bit m_down  [MaxN];
    bit m_vis   [MaxN];

    task automatic model_maze(input int cols, input int rows, input logic [15:0] sd);
        int n;
        int sx[$];
        int sy[$];
        logic [15:0] l;
        int x, y, d, nx, ny, guard;
        bit moved;
        n = cols * rows;
        l = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int i = 0; i < MaxN; i++) begin
            m_right[i] = 1'b1;
            m_down[i]  = 1'b1;
            m_vis[i]   = 1'b0;
        end
        m_vis[0] = 1'b1;
        sx.push_back(0);
        sy.push_back(0);
        guard = 0;
        while (sx.size() > 0 && guard < 4 * n) begin
            x = sx[sx.size() - 1];
            y = sy[sy.size() - 1];
            moved = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!moved) begin
                    d  = (int'(l[1:0]) + i) % 4;
                    nx = x + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
                    ny = y + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
                    if (nx >= 0 && nx < cols && ny >= 0 && ny < rows && !m_vis[ny * cols + nx]) begin
                        case (d)
                            0:       m_down[ny * cols + nx] = 1'b0;
                            1:       m_right[y * cols + x]  = 1'b0;
                            2:       m_down[y * cols + x]   = 1'b0;
                            default: m_right[ny * cols + nx] = 1'b0;
                        endcase
                        m_vis[ny * cols + nx] = 1'b1;
                        sx.push_back(nx);
                        sy.push_back(ny);
                        moved = 1'b1;
                    end
                end
            end
            if (!moved) begin
                void'(sx.pop_back());
                void'(sy.pop_back());
            end
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            guard++;
        end
        if (ExitEn) m_right[n - 1] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int         sel;
        int         x;
        int         y;
        int         idx;
        bit         inr;
        logic [1:0] w;
    } rd_item_t;

    rd_item_t exp_q[$];
    logic     rd_req = 1'b0;
    int       rd_sel = 0;
    logic     req_d1 = 1'b0;
    int       sel_d1 = 0;
    int       cap_r [MaxN];
    int       cap_d [MaxN];
    rd_item_t mon_it;
    logic [1:0] mon_act;

    always @(posedge clk) begin
        req_d1 <= rd_req;
        sel_d1 <= rd_sel;
    end

    always @(negedge clk) begin
        if (req_d1) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard underflow", 32'd1, 32'd0);
            end else begin
                mon_it  = exp_q.pop_front();
                mon_act = get_walls(sel_d1);
                if (mon_it.inr) begin
                    cap_r[mon_it.idx] = int'(mon_act[1]);
                    cap_d[mon_it.idx] = int'(mon_act[0]);
                end
                chk($sformatf("rd_walls dut%0d (%0d,%0d)", mon_it.sel, mon_it.x, mon_it.y),
                    32'(mon_act), 32'(mon_it.w));
            end
        end
    end

    // Reads every cell (plus sparse out-of-range rows up to ymax-1).
    task automatic read_map(input int s, input int cols, input int rows, input int ymax);
        for (int i = 0; i < MaxN; i++) begin
            cap_r[i] = -1;
            cap_d[i] = -1;
        end
        for (int y = 0; y < ymax; y++) begin
            for (int x = 0; x < cols; x++) begin
                rd_item_t it;
                if (y >= rows && (x % 5) != 0 && x != cols - 1) continue;
                it.sel = s;
                it.x   = x;
                it.y   = y;
                it.idx = y * cols + x;
                it.inr = (y < rows);
                it.w   = it.inr ? {m_right[it.idx], m_down[it.idx]} : 2'b11;
                exp_q.push_back(it);
                rx     = 4'(x);
                ry     = 4'(y);
                rd_sel = s;
                rd_req = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Structural properties of the captured map.
    task automatic analyze(input int cols, input int rows, input string tag);
        int n, open, bad, reach, i, x, y;
        int seen [MaxN];
        int q[$];
        n = cols * rows;
        open = 0;
        bad  = 0;
        for (int c = 0; c < n; c++) begin
            x = c % cols;
            y = c / cols;
            seen[c] = 0;
            if (x < cols - 1 && cap_r[c] == 0) open++;
            if (y < rows - 1 && cap_d[c] == 0) open++;
            if (x == cols - 1 && cap_r[c] != 1 && !(ExitEn && c == n - 1)) bad++;
            if (y == rows - 1 && cap_d[c] != 1) bad++;
        end
        reach = 0;
        seen[0] = 1;
        q.push_back(0);
        while (q.size() > 0) begin
            i = q.pop_front();
            reach++;
            x = i % cols;
            y = i / cols;
            if (x < cols - 1 && cap_r[i] == 0 && seen[i + 1] == 0) begin
                seen[i + 1] = 1; q.push_back(i + 1);
            end
            if (y < rows - 1 && cap_d[i] == 0 && seen[i + cols] == 0) begin
                seen[i + cols] = 1; q.push_back(i + cols);
            end
            if (x > 0 && cap_r[i - 1] == 0 && seen[i - 1] == 0) begin
                seen[i - 1] = 1; q.push_back(i - 1);
            end
            if (y > 0 && cap_d[i - cols] == 0 && seen[i - cols] == 0) begin
                seen[i - cols] = 1; q.push_back(i - cols);
            end
        end
        chk({tag, " open internal walls"}, 32'(open), 32'(n - 1));
        chk({tag, " reachable cells"}, 32'(reach), 32'(n));
        chk({tag, " closed boundary"}, 32'(bad), 32'd0);
    endtask

    // Pulses start on instance s and checks busy/finish timing.
    task automatic run_gen(input int s, input int cols, input int rows, input logic [15:0] sd,
                           input bit disturb, input string tag);
        int n, fin_at, bad;
        n = cols * rows;
        seed_v     = sd;
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        chk({tag, " busy right after start edge"}, 32'(get_busy(s)), 32'd0);
        fin_at = -1;
        bad    = 0;
        for (int c = 1; c <= 4 * n + 8; c++) begin
            @(posedge clk);
            #1;
            // Ignored requests: one during CLEAR, one mid-CARVE.
            start_v[s] = disturb && (c == 3 || c == n + 5);
            if (get_finish(s) === 1'b1) begin
                fin_at = c;
                break;
            end
            if (get_busy(s) !== 1'b1) bad++;
        end
        start_v[s] = 1'b0;
        chk({tag, " finish cycle"}, 32'(fin_at), 32'(3 * n));
        chk({tag, " busy held while generating"}, 32'(bad), 32'd0);
        chk({tag, " busy low with finish"}, 32'(get_busy(s)), 32'd0);
    endtask

    task automatic full_case(input int s, input int cols, input int rows, input logic [15:0] sd,
                             input bit disturb, input int ymax, input string tag);
        run_gen(s, cols, rows, sd, disturb, tag);
        model_maze(cols, rows, sd);
        read_map(s, cols, rows, ymax);
        analyze(cols, rows, tag);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] rs;
        rst     = 1'b1;
        start_v = 3'b111;
        seed_v  = 16'h1234;
        rx      = '0;
        ry      = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset busy dut%0d", s), 32'(get_busy(s)), 32'd0);
            chk($sformatf("reset finish dut%0d", s), 32'(get_finish(s)), 32'd0);
            chk($sformatf("reset rd_walls dut%0d", s), 32'(get_walls(s)), 32'd0);
        end
        rst     = 1'b0;
        start_v = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++)
            chk($sformatf("start under reset ignored dut%0d", s), 32'(get_busy(s)), 32'd0);

        full_case(0, 4, 4, 16'h1234, 1'b0, 4, "4x4 seed 1234");
        full_case(0, 4, 4, 16'h1234, 1'b1, 4, "4x4 seed 1234 regen+pulses");
        full_case(0, 4, 4, 16'h0000, 1'b0, 4, "4x4 seed 0");
        full_case(0, 4, 4, 16'hACE1, 1'b0, 4, "4x4 seed ACE1");
        for (int k = 0; k < 3; k++) begin
            rs = 16'($urandom_range(0, 65535));
            full_case(0, 4, 4, rs, 1'($urandom_range(0, 1)), 4, $sformatf("4x4 seed %h", rs));
        end

        full_case(2, 2, 2, 16'h1234, 1'b0, 2, "2x2 seed 1234");
        rs = 16'($urandom_range(1, 65535));
        full_case(2, 2, 2, rs, 1'b1, 2, $sformatf("2x2 seed %h", rs));
        chk("2x2 exit cell walls", 32'({cap_r[3][0], cap_d[3][0]}), ExitEn ? 32'd1 : 32'd3);

        // 16x12: reset while carving, then a clean run.
        seed_v     = 16'hBEEF;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        repeat (192 + 20) @(posedge clk);
        #1;
        chk("16x12 carving before reset", 32'(get_busy(1)), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("16x12 busy after mid-carve reset", 32'(get_busy(1)), 32'd0);
        chk("16x12 finish after mid-carve reset", 32'(get_finish(1)), 32'd0);
        chk("16x12 rd_walls after mid-carve reset", 32'(get_walls(1)), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("16x12 stays idle after reset", 32'({get_busy(1), get_finish(1)}), 32'd0);
        rs = 16'($urandom_range(0, 65535));
        full_case(1, 16, 12, rs, 1'b1, 16, $sformatf("16x12 seed %h", rs));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard stop in case a wait above never resolves.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks of expected more", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maze_generator.md
# maze_generator

Parametrised perfect-maze generator. On `start` it clears a COLS×ROWS cell grid and carves a spanning tree using an LFSR-driven depth-first recursive backtracker with an explicit stack. It then holds the wall map for random-access readout by the display/render stage. It is the cell-level successor to the fixed-pattern maze carver and feeds the pixel expander downstream.

## Interface
- `COLS`, default 16, grid width in cells (≥2)
- `ROWS`, default 12, grid height in cells (≥2)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  start request; sampled in IDLE and DONE only
- `seed`  in  16  LFSR seed, sampled with `start`; 0 is replaced by 16'hACE1
- `rd_x`  in  XW=max(1,$clog2(COLS))  readout cell column
- `rd_y`  in  YW=max(1,$clog2(ROWS))  readout cell row
- `rd_walls`  out  2  {right_wall, down_wall} of cell (rd_x,rd_y), registered
- `busy`  out  1  high in CLEAR and CARVE
- `finish`  out  1  level, high in DONE

## Operation
- N = COLS*ROWS. Cell index = y*COLS + x. Per cell: `right` and `down` wall bits and a `visited` bit, all flops. Left/top outer boundary is implicit and always closed.
- Stack: N entries of {x,y}. Pointer width is $clog2(N+1).
- LFSR: 16-bit Galois, `l <= {1'b0,l[15:1]} ^ (l[0] ? 16'hB400 : 0)`. Advances once per CARVE cycle only.
- States:
  - IDLE: on `start`, load the seed and go to CLEAR.
  - CLEAR: N cycles. One cell per cycle, index 0..N-1, set walls=2'b11 and visited=0. Last cycle: mark (0,0) visited, stack={(0,0)}, go to CARVE.
  - CARVE: one step per cycle with top-of-stack (x,y).
    - Directions: 0=N, 1=E, 2=S, 3=W. Candidate order is d0=l[1:0], then d0+1, d0+2, d0+3 (mod 4). A candidate must be in-grid and unvisited.
    - If the first qualifying candidate exists, remove the shared wall and mark the neighbour visited. Then push it.
      - N clears `down` of (x,y-1).
      - E clears `right` of (x,y).
      - S clears `down` of (x,y).
      - W clears `right` of (x-1,y).
    - Otherwise pop. The pop that empties the stack goes to DONE.
  - DONE: `finish`=1. On `start`, reload the seed and go to CLEAR (regenerate).
- `start` in CLEAR/CARVE is ignored.
- Result: exactly N-1 internal walls removed, all cells reachable. `right` of column COLS-1 and `down` of row ROWS-1 are never cleared, except the configured exit.
- `rd_walls` tracks `rd_x`,`rd_y` in every state. Contents are meaningful only while `finish`=1.
- Out-of-range `rd_x`/`rd_y` returns 2'b11.

## Timing
- Reset values: `busy`=0, `finish`=0, `rd_walls`=0, state IDLE, stack pointer 0, LFSR 16'hACE1. Wall/visited contents are unspecified until CLEAR runs.
- `start` sampled at edge k: `busy`=1 after edge k+1. CLEAR covers N cycles and CARVE covers 2N-1 cycles (N-1 pushes, N pops).
- `finish`=1 and `busy`=0 after edge k+3N. Both are registered with no overlap.
- `rd_walls` latency is 1 cycle from `rd_x`/`rd_y`.
- `rst` in any state, including mid-CARVE: next edge returns IDLE with reset values. The previous maze is invalid.
- Generation is deterministic for a given (seed, COLS, ROWS).

## Configuration
- `MAZE_GEN_EXIT_EN` defined: on the cycle the final pop enters DONE, `right` of cell (COLS-1,ROWS-1) is also cleared (exit opening). That cell then reads `rd_walls[1]`=0.
- Not defined: that wall stays 1, no exit opening is produced, and the logic is absent.
- Cycle counts are identical in both builds.

## Test plan
- Reset: assert `rst` 2 cycles -> `busy`=0, `finish`=0, `rd_walls`=0. `start` with `rst`=1 is ignored.
- 4×4, seed 16'h1234, `start` at edge k -> `busy` rises after k+1, `finish` rises exactly after k+48. Full readout shows 15 open internal walls, BFS from (0,0) reaches all 16 cells, and every boundary wall = 1.
- Same 4×4 run repeated with seed 16'h1234, then seed 0 vs 16'hACE1 -> bit-identical wall maps in each pair.
- Pulse `start` during CLEAR and again mid-CARVE -> no restart; `finish` still after k+48. A `start` in DONE regenerates, with `finish` low for 48 cycles.
- `rst` at cycle 20 of CARVE on 16×12 -> IDLE next edge. A fresh `start` gives `finish` exactly 576 cycles later, with 191 open walls and all cells connected.
- Build with `MAZE_GEN_EXIT_EN`, 2×2 -> `finish` after 12 cycles, `rd_walls` of (1,1) = {0,1}, 3 internal walls open. The build without the macro reads {1,1}.
